inst_data_memory_ws: RTL and testbench

Parametrised unified instruction/data word memory for the multi-cycle MIPS CPU, replacing the fixed single-cycle RAM. It adds four features:
- configurable read/write wait states with a ready/busy handshake;
- byte-lane writes for `sb`/`sh`;
- a multi-cycle data-region clear after reset;
- a program-load port for filling the instruction region.

It sits between the CPU's shared address/data path and the control FSM, which stalls on `Mem_ready`.

---
 rtl/inst_data_memory_ws.sv | 181 ++++++++++++++++++
 tb/tb_inst_data_memory_ws.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/inst_data_memory_ws.sv
// Unified instruction/data word memory with wait states, byte-lane writes,
// post-reset data-region clear and a program-load port.
`timescale 1ns/1ps
module inst_data_memory_ws #(
    parameter int DEPTH_BIT  = 8,
    parameter int INST_WORDS = 32,
    parameter int LATENCY    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Address,
    input  logic [31:0]          Write_data,
    input  logic [3:0]           Byte_en,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 Prog_we,
    input  logic [DEPTH_BIT-1:0] Prog_addr,
    input  logic [31:0]          Prog_data,
    output logic [31:0]          Mem_data,
    output logic                 Mem_ready,
    output logic                 Mem_busy,
    output logic                 Addr_error
);
    localparam int WORDS = 1 << DEPTH_BIT;
    localparam bit CLEAR_SKIP = (INST_WORDS >= WORDS);
    localparam logic [DEPTH_BIT-1:0] CLR_START = DEPTH_BIT'(INST_WORDS);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t               state_q, state_d;
    logic [DEPTH_BIT-1:0] clr_idx_q, clr_idx_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [DEPTH_BIT-1:0] idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic                 is_write_q, is_write_d;
    logic                 err_q, err_d;
    logic                 mem_ready_q, mem_ready_d;
    logic                 addr_error_q, addr_error_d;
    logic                 mem_busy_q, mem_busy_d;

    logic                 req, req_err;
    logic                 do_access, clear_we, cpu_we;
    logic [DEPTH_BIT-1:0] acc_idx;
    logic [31:0]          acc_wdata;
    logic [3:0]           acc_be;
    logic                 acc_write, acc_err;
    logic                 addr_lsb_unused;

    assign req             = MemRead | MemWrite;
    assign req_err         = (|Address[31:DEPTH_BIT+2]) | (MemRead & MemWrite);
    assign addr_lsb_unused = ^Address[1:0];

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        is_write_d   = is_write_q;
        err_d        = err_q;
        mem_ready_d  = 1'b0;
        addr_error_d = 1'b0;
        do_access    = 1'b0;
        clear_we     = 1'b0;
        acc_idx      = idx_q;
        acc_wdata    = wdata_q;
        acc_be       = be_q;
        acc_write    = is_write_q;
        acc_err      = err_q;

        case (state_q)
            ST_CLEAR: begin
                clear_we  = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == '1)
                    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req) begin
                    idx_d      = Address[DEPTH_BIT+1:2];
                    wdata_d    = Write_data;
                    be_d       = Byte_en;
                    is_write_d = MemWrite;
                    err_d      = req_err;
                    if (LATENCY == 0) begin
                        // Zero wait states: the access uses the live inputs at the latch edge.
                        do_access = 1'b1;
                        acc_idx   = Address[DEPTH_BIT+1:2];
                        acc_wdata = Write_data;
                        acc_be    = Byte_en;
                        acc_write = MemWrite;
                        acc_err   = req_err;
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d   = 3'(LATENCY);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 3'd1) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_access) begin
            mem_ready_d  = 1'b1;
            addr_error_d = acc_err;
        end

        if (reset) begin
            state_d      = CLEAR_SKIP ? ST_IDLE : ST_CLEAR;
            clr_idx_d    = CLR_START;
            cnt_d        = '0;
            mem_ready_d  = 1'b0;
            addr_error_d = 1'b0;
            do_access    = 1'b0;
            clear_we     = 1'b0;
        end
        mem_busy_d = reset | (state_d != ST_IDLE);
    end

    assign cpu_we = do_access & acc_write & ~acc_err;

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        clr_idx_q    <= clr_idx_d;
        cnt_q        <= cnt_d;
        idx_q        <= idx_d;
        wdata_q      <= wdata_d;
        be_q         <= be_d;
        is_write_q   <= is_write_d;
        err_q        <= err_d;
        mem_ready_q  <= mem_ready_d;
        addr_error_q <= addr_error_d;
        mem_busy_q   <= mem_busy_d;
    end

    // One byte-wide RAM per lane; program writes come last so they win same-word collisions.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    if (clear_we)
                        lane_mem[clr_idx_q] <= 8'h00;
                    if (cpu_we && acc_be[gi])
                        lane_mem[acc_idx] <= acc_wdata[8*gi +: 8];
                    if (Prog_we)
                        lane_mem[Prog_addr] <= Prog_data[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (reset)
                    rd_q <= 8'h00;
                else if (do_access) begin
                    if (acc_err)
                        rd_q <= 8'h00;
                    else if (!acc_write)
                        rd_q <= lane_mem[acc_idx];
                end
            end

            assign Mem_data[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign Mem_ready  = mem_ready_q;
    assign Mem_busy   = mem_busy_q;
    assign Addr_error = addr_error_q;
endmodule

// File: tb/tb_inst_data_memory_ws.sv
// Directed bench: one memory with two wait states, one with zero wait states.
`timescale 1ns/1ps
module tb_inst_data_memory_ws;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address, write_data, prog_data, mem_data;
    logic [3:0]  byte_en;
    logic        mem_read, mem_write, prog_we, mem_ready, mem_busy, addr_error;
    logic [7:0]  prog_addr;

    logic [31:0] z_address, z_write_data, z_prog_data, z_mem_data;
    logic [3:0]  z_byte_en;
    logic        z_mem_read, z_mem_write, z_prog_we, z_mem_ready, z_mem_busy, z_addr_error;
    logic [7:0]  z_prog_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_data_memory_ws #(.DEPTH_BIT(8), .INST_WORDS(32), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .Address(address), .Write_data(write_data),
        .Byte_en(byte_en), .MemRead(mem_read), .MemWrite(mem_write),
        .Prog_we(prog_we), .Prog_addr(prog_addr), .Prog_data(prog_data),
        .Mem_data(mem_data), .Mem_ready(mem_ready), .Mem_busy(mem_busy),
        .Addr_error(addr_error)
    );

    inst_data_memory_ws #(.DEPTH_BIT(8), .INST_WORDS(32), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .Address(z_address), .Write_data(z_write_data),
        .Byte_en(z_byte_en), .MemRead(z_mem_read), .MemWrite(z_mem_write),
        .Prog_we(z_prog_we), .Prog_addr(z_prog_addr), .Prog_data(z_prog_data),
        .Mem_data(z_mem_data), .Mem_ready(z_mem_ready), .Mem_busy(z_mem_busy),
        .Addr_error(z_addr_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic prog(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        $display("prog  word=%0d data=%h", a, d);
    endtask

    // Issues one request on the LATENCY=2 memory, checks latency, data and error flag.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_data,
                          input logic exp_err);
        int cyc;
        mem_read = rd; mem_write = wr; address = addr; write_data = wd; byte_en = be;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        cyc = 0;
        while (!mem_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, 32'd2);
        check({tag, "_data"}, mem_data, exp_data);
        check({tag, "_err"}, {31'b0, addr_error}, {31'b0, exp_err});
        $display("%s rd=%0b wr=%0b addr=%h be=%b data=%h err=%0b", tag, rd, wr, addr, be, mem_data, addr_error);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int pulses;
        reset = 1'b1;
        address = '0; write_data = '0; byte_en = '0; mem_read = 0; mem_write = 0;
        prog_we = 0; prog_addr = '0; prog_data = '0;
        z_address = '0; z_write_data = '0; z_byte_en = '0; z_mem_read = 0; z_mem_write = 0;
        z_prog_we = 0; z_prog_addr = '0; z_prog_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_busy", {31'b0, mem_busy}, 32'd1);
        check("rst_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_data", mem_data, 32'd0);
        check("rst_err", {31'b0, addr_error}, 32'd0);

        n = 0;
        while (mem_busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("clear_cycles", n, 32'd224);
        check("clear_busy0_z", {31'b0, z_mem_busy}, 32'd0);
        $display("clear done after %0d cycles", n);

        prog(8'd0, 32'h12345678);
        access("rd80", 1, 0, 32'h80, 0, 4'h0, 32'h0, 0);
        access("rd00", 1, 0, 32'h00, 0, 4'h0, 32'h12345678, 0);
        access("wr84", 0, 1, 32'h84, 32'hDEADBEEF, 4'hF, 32'h12345678, 0);
        access("rd84", 1, 0, 32'h84, 0, 4'h0, 32'hDEADBEEF, 0);
        prog(8'd34, 32'h11223344);
        access("wr88a", 0, 1, 32'h88, 32'h00AA0000, 4'b0100, 32'hDEADBEEF, 0);
        access("wr88b", 0, 1, 32'h88, 32'h0000BBCC, 4'b0011, 32'hDEADBEEF, 0);
        access("rd88", 1, 0, 32'h88, 0, 4'h0, 32'h11AABBCC, 0);
        access("wr84nop", 0, 1, 32'h84, 32'h0, 4'b0000, 32'h11AABBCC, 0);
        access("rd84b", 1, 0, 32'h84, 0, 4'h0, 32'hDEADBEEF, 0);
        access("wr400", 0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
        access("rd00b", 1, 0, 32'h00, 0, 4'h0, 32'h12345678, 0);
        access("rdwr84", 1, 1, 32'h84, 32'h0, 4'hF, 32'h0, 1);
        access("rd87", 1, 0, 32'h87, 0, 4'h0, 32'hDEADBEEF, 0);

        // Zero-wait memory: back-to-back reads and a program/CPU write collision.
        z_prog_we = 1; z_prog_addr = 8'd5; z_prog_data = 32'hA5A5A5A5;
        @(posedge clk); #1;
        z_prog_addr = 8'd6; z_prog_data = 32'h5A5A5A5A;
        @(posedge clk); #1;
        z_prog_we = 0;
        z_mem_read = 1; z_address = 32'h14;
        @(posedge clk); #1;
        z_mem_read = 0;
        check("z_rd14_ready", {31'b0, z_mem_ready}, 32'd1);
        check("z_rd14_data", z_mem_data, 32'hA5A5A5A5);
        $display("z_rd14 data=%h", z_mem_data);
        @(posedge clk); #1;
        check("z_gap_ready", {31'b0, z_mem_ready}, 32'd0);
        z_mem_read = 1; z_address = 32'h18;
        @(posedge clk); #1;
        z_mem_read = 0;
        check("z_rd18_ready", {31'b0, z_mem_ready}, 32'd1);
        check("z_rd18_data", z_mem_data, 32'h5A5A5A5A);
        $display("z_rd18 data=%h", z_mem_data);
        @(posedge clk); #1;
        z_mem_write = 1; z_address = 32'h14; z_write_data = 32'h11111111; z_byte_en = 4'hF;
        z_prog_we = 1; z_prog_addr = 8'd5; z_prog_data = 32'h22222222;
        @(posedge clk); #1;
        z_mem_write = 0; z_prog_we = 0;
        check("z_wrcol_ready", {31'b0, z_mem_ready}, 32'd1);
        check("z_wrcol_err", {31'b0, z_addr_error}, 32'd0);
        $display("z_wr14 collide with prog");
        @(posedge clk); #1;
        z_mem_read = 1; z_address = 32'h14;
        @(posedge clk); #1;
        z_mem_read = 0;
        check("z_rdcol_data", z_mem_data, 32'h22222222);
        $display("z_rd14 data=%h", z_mem_data);
        @(posedge clk); #1;

        // Reset during WAIT of a pending write drops it.
        mem_write = 1; address = 32'h90; write_data = 32'hCAFEF00D; byte_en = 4'hF;
        @(posedge clk); #1;
        mem_write = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("wrst_ready", {31'b0, mem_ready}, 32'd0);
        check("wrst_data", mem_data, 32'd0);
        n = 0; pulses = 0;
        while (mem_busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (mem_ready) pulses++;
        end
        check("wrst_pulses", pulses, 32'd0);
        check("wrst_clear", n, 32'd224);
        $display("reset during wait, clear after %0d cycles", n);
        access("rd90", 1, 0, 32'h90, 0, 4'h0, 32'h0, 0);
        access("rd88c", 1, 0, 32'h88, 0, 4'h0, 32'h0, 0);
        access("rd00c", 1, 0, 32'h00, 0, 4'h0, 32'h12345678, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
